// File: rtl/seg7_pkg.sv
// Shared definitions for the scanned 7-segment display front end:
// load-mode encodings, the blank pattern and the active-low hex glyph set.
package seg7_pkg;

   typedef enum logic [1:0] {
      MODE_LOAD = 2'b00,
      MODE_ADD  = 2'b01,
      MODE_AND  = 2'b10,
      MODE_CLR  = 2'b11
   } mode_e;

   // All segments off on a common-anode bank.
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-low {g,f,e,d,c,b,a} glyphs; entry n is the glyph for hex digit n.
   localparam logic [15:0][6:0] HEX_GLYPH = {
      7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
      7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
      7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
      7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
   };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low 7-segment glyph decoder.
module hex_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = HEX_GLYPH[nibble];

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed N-digit hex display with a switch-loaded value register.
// A load event (rising edge of LOAD) applies LOAD/ADD/AND/CLR to the value;
// a slot divider steps the scanned digit every DIV cycles. All outputs are
// registered and active-low.
// Optional build macro: LEADING_ZERO_BLANK_EN -- blanks digits above the
// most significant non-zero nibble (digit 0 is always shown).
module seg7_scan_display
   import seg7_pkg::*;
#(
   parameter int DIGITS   = 8,
   parameter int DIV      = 100000,
   parameter int DP_DIGIT = 0
)
(
   input  logic                  CLK100MHZ,
   input  logic                  CPU_RESETN,
   input  logic [1:0]            MODE,
   input  logic [4*DIGITS-1:0]   SW,
   input  logic                  LOAD,
   output logic [DIGITS-1:0]     AN,
   output logic [6:0]            C,
   output logic                  DP
);

   localparam int VW    = 4 * DIGITS;
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   // A decimal point index outside the digit range never lights.
   localparam logic             DP_EN  = (DP_DIGIT >= 0) && (DP_DIGIT < DIGITS);
   localparam logic [IDX_W-1:0] DP_IDX = DP_EN ? IDX_W'(DP_DIGIT) : '0;

   logic [DIV_W-1:0]  divider;
   logic              tick;
   logic [IDX_W-1:0]  idx;
   logic              load_q;
   logic              load_evt;
   logic [VW-1:0]     value;
   logic [VW-1:0]     value_next;
   logic [3:0]        nibble;
   logic [6:0]        glyph;
   logic [DIGITS-1:0] an_sel;
   logic              blank;
   logic              dp_next;

   assign tick     = (divider == DIV_LAST);
   assign load_evt = LOAD & ~load_q;

   // Slot divider: free-running 0..DIV-1, tick on the last count.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN)
         divider <= '0;
      else if (tick)
         divider <= '0;
      else
         divider <= divider + 1'b1;
   end

   // Scanned digit index advances once per slot and wraps after the last digit.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN)
         idx <= '0;
      else if (tick) begin
         if (idx == IDX_LAST)
            idx <= '0;
         else
            idx <= idx + 1'b1;
      end
   end

   // Delayed copy of LOAD so a held level yields a single load event.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN)
         load_q <= 1'b0;
      else
         load_q <= LOAD;
   end

   // Next value: MODE and SW only matter on the load event; ADD wraps.
   always_comb begin
      value_next = value;
      if (load_evt) begin
         case (MODE)
            MODE_LOAD: value_next = SW;
            MODE_ADD:  value_next = value + SW;
            MODE_AND:  value_next = value & SW;
            MODE_CLR:  value_next = '0;
            default:   value_next = value;
         endcase
      end
   end

   // Value register holds between loads.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN)
         value <= '0;
      else
         value <= value_next;
   end

   // Select the nibble and one-hot (active-low) anode for the current digit.
   always_comb begin
      nibble = 4'h0;
      an_sel = '1;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            nibble    = value[4*i +: 4];
            an_sel[i] = 1'b0;
         end
      end
   end

   hex_to_seg7 u_hex_to_seg7 (
      .nibble (nibble),
      .seg    (glyph)
   );

`ifdef LEADING_ZERO_BLANK_EN
   // Blank a non-zero digit position when it and everything above it is zero.
   assign blank = (idx != '0) && ((value >> {idx, 2'b00}) == '0);
`else
   assign blank = 1'b0;
`endif

   assign dp_next = ~(DP_EN && (idx == DP_IDX));

   // Registered drive to the segment bank, one cycle behind idx/value.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         AN <= '1;
         C  <= SEG_BLANK;
         DP <= 1'b1;
      end else begin
         AN <= blank ? '1 : an_sel;
         C  <= blank ? SEG_BLANK : glyph;
         DP <= dp_next;
      end
   end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display (DIGITS=8, DIV=4, DP_DIGIT=0).
// A reference model predicts each cycle's AN/C/DP from the cycle count since
// reset and a value updated by load events; a monitor pops and compares.
module tb_seg7_scan_display;

   localparam int DIGITS   = 8;
   localparam int DIV      = 4;
   localparam int DP_DIGIT = 0;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic [1:0]  mode  = 2'b00;
   logic [31:0] sw    = 32'h0;
   logic        load  = 1'b0;
   logic [7:0]  an;
   logic [6:0]  c;
   logic        dp;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [7:0] an;
      logic [6:0] c;
      logic       dp;
   } exp_t;

   exp_t sb[$];

   logic [31:0] m_value     = 32'h0;
   logic        m_prev_load = 1'b0;
   int          m_cycles    = 0;

   seg7_scan_display #(
      .DIGITS   (DIGITS),
      .DIV      (DIV),
      .DP_DIGIT (DP_DIGIT)
   ) dut (
      .CLK100MHZ  (clk),
      .CPU_RESETN (rst_n),
      .MODE       (mode),
      .SW         (sw),
      .LOAD       (load),
      .AN         (an),
      .C          (c),
      .DP         (dp)
   );

   always #5 clk = ~clk;

   // Glyph from the lit-segment pattern (active-high gfedcba), then inverted.
   function automatic logic [6:0] glyph_of(input logic [3:0] n);
      logic [6:0] lit;
      case (n)
         4'h0: lit = 7'h3F;  4'h1: lit = 7'h06;  4'h2: lit = 7'h5B;  4'h3: lit = 7'h4F;
         4'h4: lit = 7'h66;  4'h5: lit = 7'h6D;  4'h6: lit = 7'h7D;  4'h7: lit = 7'h07;
         4'h8: lit = 7'h7F;  4'h9: lit = 7'h6F;  4'hA: lit = 7'h77;  4'hB: lit = 7'h7C;
         4'hC: lit = 7'h39;  4'hD: lit = 7'h5E;  4'hE: lit = 7'h79;  4'hF: lit = 7'h71;
         default: lit = 7'h00;
      endcase
      return ~lit;
   endfunction

   function automatic exp_t predict(input logic [31:0] v, input int digit);
      exp_t       e;
      logic [3:0] nib;
      bit         all_zero;
      nib  = 4'((v >> (4 * digit)) & 32'hF);
      e.an = ~(8'h01 << digit);
      e.c  = glyph_of(nib);
      e.dp = (digit == DP_DIGIT) ? 1'b0 : 1'b1;
      all_zero = 1'b1;
      for (int k = digit; k < DIGITS; k++)
         if (((v >> (4 * k)) & 32'hF) != 32'h0) all_zero = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      if (digit > 0 && all_zero) begin
         e.an = 8'hFF;
         e.c  = 7'h7F;
      end
`endif
      return e;
   endfunction

   function automatic logic [31:0] apply_op(input logic [31:0] v, input logic [1:0] m,
                                            input logic [31:0] s);
      logic [31:0] r;
      case (m)
         2'b00:   r = s;
         2'b01:   r = v + s;
         2'b10:   r = v & s;
         default: r = 32'h0;
      endcase
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: outputs after an edge reflect the state before it.
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_value     = 32'h0;
         m_prev_load = 1'b0;
         m_cycles    = 0;
         sb.delete();
      end else begin
         sb.push_back(predict(m_value, (m_cycles / DIV) % DIGITS));
         if (load && !m_prev_load) m_value = apply_op(m_value, mode, sw);
         m_prev_load = load;
         m_cycles++;
      end
   end

   // Monitor: compare the DUT outputs on the falling edge.
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (rst_n && sb.size() > 0) begin
         e = sb.pop_front();
         check("scan_an", an, e.an);
         check("scan_c",  c,  e.c);
         check("scan_dp", dp, e.dp);
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_load(input logic [1:0] m, input logic [31:0] s);
      @(negedge clk);
      mode = m;
      sw   = s;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      mode = 2'($urandom);
      sw   = $urandom;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_an"}, an, 8'hFF);
      check({tag, "_c"},  c,  7'h7F);
      check({tag, "_dp"}, dp, 1'b1);
   endtask

   initial begin
      // Power-on reset: outputs clear without any clock edge.
      #1 rst_n = 1'b0;
      #1 check_reset_outputs("rst0");
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      idle(12);

      // Scan through digits 0..7.
      do_load(2'b00, 32'h76543210);
      idle(36);

      // ADD wraps modulo 2^32.
      do_load(2'b00, 32'hFFFFFFFF);
      do_load(2'b01, 32'h00000002);
      idle(36);

      // Held LOAD gives exactly one event, even as SW changes.
      @(negedge clk);
      mode = 2'b01;
      sw   = 32'h1;
      load = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         sw = $urandom;
      end
      load = 1'b0;
      idle(2);
      do_load(2'b01, 32'h1);
      idle(36);

      // AND then CLR.
      do_load(2'b00, 32'hABCD1234);
      do_load(2'b10, 32'h0F0F0F0F);
      idle(36);
      do_load(2'b11, $urandom);
      idle(36);

      // Leading-zero patterns.
      do_load(2'b00, 32'h00000A05);
      idle(36);
      do_load(2'b00, 32'h0);
      idle(36);

      // Randomized loads, some with short operands, some back-to-back.
      for (int i = 0; i < 60; i++) begin
         logic [31:0] s;
         s = $urandom;
         if ($urandom_range(0, 1) == 1) s = s >> (4 * $urandom_range(1, 7));
         do_load(2'($urandom_range(0, 3)), s);
         idle($urandom_range(0, 40));
      end

      // Mid-scan reset with LOAD held high across release.
      idle(5);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("rst1");
      mode = 2'b00;
      sw   = 32'hC0FFEE59;
      load = 1'b1;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      idle(3);
      load = 1'b0;
      idle(36);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
